reg_stream_drain: RTL and testbench
===================================

# reg_stream_drain

Consumer-side companion to the write-enabled 2-cycle delay register used in the signed datapath. It watches the register's write strobe, samples the register output exactly when a written value emerges, and queues each value in a small FIFO. Values leave on a valid/ready stream. A credit signal back to the writer guarantees that no value in flight is lost under downstream backpressure.

## Interface
Parameters:
- DATA_W, 32, width of the captured signed word (treated as opaque bits).
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- LAT, 2, cycles from a register write strobe to the value appearing on the register output; ≥ 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; clears all state immediately.
- wr_en_mon  in  1  copy of the write strobe driven into the upstream delay register.
- reg_s  in  DATA_W  upstream register output.
- can_write  out  1  credit: writer may assert the strobe this cycle.
- out_valid  out  1  out_data holds the oldest queued value.
- out_ready  in  1  downstream accepts when high together with out_valid.
- out_data  out  DATA_W  head of FIFO.
- level  out  $clog2(DEPTH)+1  number of FIFO entries.
- flush  in  1  synchronous clear of FIFO and in-flight tags.
- overflow_err  out  1  sticky; a value arrived while the FIFO was full.

## Operation
- Tag pipeline: LAT-stage shift register of valid bits. Stage 0 loads wr_en_mon; stage k loads stage k-1 every cycle.
- Push when the last tag stage is 1. reg_s is written at the tail in that cycle.
- Pop when out_valid && out_ready. Head advances.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH, plus a count register. level = count.
- Push and pop in the same cycle:
  - count is unchanged.
  - Allowed when full: the pop frees the slot.
  - Allowed when empty: no bypass, so the value appears next cycle.
- Credit: inflight = number of set tag bits. can_write = (count + inflight) < DEPTH, combinational from registered state.
  - A same-cycle pop is not credited; the rule is conservative.
- Overflow: a push while count == DEPTH and no simultaneous pop is dropped.
  - overflow_err sets and stays 1 until reset.
  - Pointers and count are unchanged.
- Flush has priority over push and pop. Next cycle: count = 0, pointers = 0, all tags = 0, out_valid = 0.
  - wr_en_mon in the flush cycle is discarded.
  - overflow_err is not cleared.
- out_data = buffer[rd_ptr] whenever out_valid. It is 0 after reset and don't-care otherwise while empty.

## Timing
- Reset values: can_write = 1, out_valid = 0, out_data = 0, level = 0, overflow_err = 0, all tags = 0, pointers = 0.
- Strobe at cycle t: the value is sampled from reg_s in cycle t+LAT. out_valid rises at cycle t+LAT+1, a latency of LAT+1 from strobe to output.
- Back-to-back strobes give one push per cycle. Throughput is 1 word/cycle with out_ready held high.
- out_valid/out_data are registered (from FIFO state). out_ready has no combinational path to out_valid.
- Reset asserted mid-operation: all state clears asynchronously, and in-flight tags are lost. Values already in the upstream register are not recovered.

## Test plan
- Single strobe, LAT=2, reg_s=0x0000_0005 in cycle t+2 -> out_valid=1 at t+3 with out_data=5, level=1; pop -> level=0.
- 4 strobes back-to-back carrying −1, 2, −3, 4 (0xFFFF_FFFF, 2, 0xFFFF_FFFD, 4), out_ready=0 -> can_write drops once count+inflight=4; level reaches 4; drained in order −1, 2, −3, 4.
- FIFO full with out_ready=1 and push in the same cycle -> level stays 4, no overflow_err; order preserved across pointer wrap (≥ 9 words streamed).
- Strobe ignoring can_write=0 with FIFO full, out_ready=0 -> overflow_err=1 sticky, level stays 4, dropped word never appears.
- flush with 3 queued and 2 in flight -> next cycle level=0, out_valid=0, can_write=1; no word emerges in the following LAT+2 cycles.
- rst_n pulsed low asynchronously mid-stream -> all outputs at reset values before the next clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/reg_stream_drain.sv
// reg_stream_drain: tags delay-register writes, captures emerging values into a credited FIFO stream
module reg_stream_drain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LAT    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_mon,
  input  logic [DATA_W-1:0]        reg_s,
  output logic                     can_write,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     flush,
  output logic                     overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(DEPTH + LAT + 1);
  logic [LAT-1:0]    tags;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [SW-1:0]     inflight;
  logic              push, pop, full, accept;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + SW'(tags[i]);
  end
  assign push      = tags[LAT-1];
  assign pop       = out_valid && out_ready;
  assign full      = count == CW'(DEPTH);
  assign accept    = push && (!full || pop);
  // credit ignores a same-cycle pop so the writer never outruns free slots
  assign can_write = (SW'(count) + inflight) < SW'(DEPTH);
  assign out_valid = count != '0;
  assign out_data  = mem[rd_ptr];
  assign level     = count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags         <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      tags   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      tags[0] <= wr_en_mon;
      for (int k = 1; k < LAT; k++) tags[k] <= tags[k-1];
      if (accept) begin
        mem[wr_ptr] <= reg_s;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && full && !pop) overflow_err <= 1'b1;
      count <= count + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_reg_stream_drain.sv
// tb_reg_stream_drain: scoreboard bench for reg_stream_drain behind a modelled 2-cycle delay register
module tb_reg_stream_drain;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int LAT = 2;
  logic clk = 0, rst_n = 0, wr_en_mon = 0, out_ready = 0, flush = 0;
  logic [DW-1:0] din = '0, d0 = '0, reg_s = '0;
  logic can_write, out_valid, overflow_err;
  logic [DW-1:0] out_data;
  logic [2:0] level;
  int vectors = 0, errors = 0;
  logic [DW-1:0] exp_q[$];

  reg_stream_drain #(.DATA_W(DW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_mon(wr_en_mon), .reg_s(reg_s),
    .can_write(can_write), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .flush(flush), .overflow_err(overflow_err));

  always #5 clk = ~clk;

  // upstream write-enabled register, value visible on reg_s two cycles after the strobe
  always @(posedge clk) begin
    if (wr_en_mon) d0 <= din;
    reg_s <= d0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (can_write !== 1'b1) begin errors++; $display("FAIL reset_can_write got %b exp 1", can_write); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    vectors++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow_err); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    wr_en_mon = 1; din = 32'h5; exp_q.push_back(32'h5);
    tick();
    wr_en_mon = 0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
    tick();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    vectors++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL single_data got %h exp %h", out_data, exp_q[0]); end
    vectors++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
    out_ready = 1; void'(exp_q.pop_front());
    tick();
    out_ready = 0;
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_after_pop got %0d exp 0", level); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v[4];
    v = '{32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFD, 32'h4};
    for (int i = 0; i < 4; i++) begin
      vectors++; if (can_write !== 1'b1) begin errors++; $display("FAIL b2b_credit_%0d got %b exp 1", i, can_write); end
      wr_en_mon = 1; din = v[i]; exp_q.push_back(v[i]);
      tick();
    end
    wr_en_mon = 0;
    vectors++; if (can_write !== 1'b0) begin errors++; $display("FAIL b2b_credit_exhausted got %b exp 0", can_write); end
    tick(); tick();
    vectors++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level got %0d exp 4", level); end
    vectors++; if (can_write !== 1'b0) begin errors++; $display("FAIL b2b_credit_full got %b exp 0", can_write); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL b2b_drain_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    out_ready = 0;
    vectors++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got level=%0d v=%b exp 0 0", level, out_valid); end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 26; c++) begin
      if (c >= 6 && c <= 15) begin
        vectors++; if (level !== 3'd4) begin errors++; $display("FAIL wrap_level_c%0d got %0d exp 4", c, level); end
      end
      wr_en_mon = c < 13;
      din = $urandom;
      if (wr_en_mon) exp_q.push_back(din);
      out_ready = c >= 6;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_extra_word got %h exp none", out_data); end
        else begin
          if (out_data !== exp_q[0]) begin errors++; $display("FAIL wrap_data_c%0d got %h exp %h", c, out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      tick();
    end
    wr_en_mon = 0; out_ready = 0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing got %0d left exp 0", exp_q.size()); end
    vectors++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL wrap_overflow got %b exp 0", overflow_err); end
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_level_end got %0d exp 0", level); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 5; c++) begin
      wr_en_mon = 1; din = 32'hF100 + c;
      tick();
    end
    vectors++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre_level got %0d exp 3", level); end
    flush = 1; din = 32'hF1FF;
    tick();
    flush = 0; wr_en_mon = 0;
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    vectors++; if (can_write !== 1'b1) begin errors++; $display("FAIL flush_credit got %b exp 1", can_write); end
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost_%0d got %b exp 0", c, out_valid); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      wr_en_mon = 1; din = 32'hA000 + i; exp_q.push_back(din);
      tick();
    end
    wr_en_mon = 0;
    tick(); tick();
    vectors++; if (overflow_err !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL ovf_pre got err=%b level=%0d exp 0 4", overflow_err, level); end
    wr_en_mon = 1; din = 32'hDEAD_BEEF;
    tick();
    wr_en_mon = 0;
    tick(); tick();
    vectors++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_err); end
    vectors++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
    tick(); tick();
    vectors++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_err); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL ovf_drain_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped_word got v=%b d=%h exp v=0", out_valid, out_data); end
    out_ready = 0;
    vectors++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky_drained got %b exp 1", overflow_err); end
  endtask

  task automatic test_async_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      wr_en_mon = 1; din = 32'hB000 + i;
      tick();
    end
    wr_en_mon = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    vectors++; if (can_write !== 1'b1) begin errors++; $display("FAIL arst_can_write got %b exp 1", can_write); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b exp 0", out_valid); end
    vectors++; if (out_data !== '0) begin errors++; $display("FAIL arst_out_data got %h exp 0", out_data); end
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", level); end
    vectors++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL arst_overflow got %b exp 0", overflow_err); end
    tick(); tick();
    rst_n = 1;
    exp_q.delete();
    tick();
    wr_en_mon = 1; din = 32'h1234_5678; exp_q.push_back(din);
    tick();
    wr_en_mon = 0;
    tick(); tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin errors++; $display("FAIL arst_resume got v=%b d=%h exp v=1 d=%h", out_valid, out_data, exp_q[0]); end
    vectors++; if (level !== 3'd1) begin errors++; $display("FAIL arst_resume_level got %0d exp 1", level); end
    out_ready = 1; void'(exp_q.pop_front());
    tick();
    out_ready = 0;
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL arst_resume_pop got %0d exp 0", level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
